demux_1a8_6b_reg: RTL and testbench
===================================

Name: demux_1a8_6b_reg

Overview:
- Registered 1-to-8 demultiplexer for 6-bit data. It is the distribution-side counterpart of the 8:1 operand mux.
- Steers a single 6-bit input stream into eight hold registers, either by explicit select or by an auto-incrementing write pointer.
- Tracks per-channel valid flags with consumer acknowledge, a full flag and a sticky overwrite error.
- Sits between the operand source and the ALU operand mux inputs D0..D7.

Parameters:
- WIDTH, 6, data width per channel. The 3-bit select and 8-channel count are fixed.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- din  input  WIDTH  write data
- sel  input  3  target channel in manual mode
- wr_en  input  1  write strobe, one write per cycle when high
- auto_mode  input  1  1 = target is wptr; 0 = target is sel
- clr  input  1  synchronous clear
- ack  input  8  per-channel consume acknowledge
- q_bus  output  8*WIDTH  channel i data on q_bus[WIDTH*i+WIDTH-1 : WIDTH*i]
- vld  output  8  per-channel valid flags
- full  output  1  high when all eight vld bits are 1
- ovf  output  1  sticky overwrite error
- wptr  output  3  current auto-mode write pointer

Behaviour:
- Clock and reset (already decided): one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, any time, including mid-sequence): q_bus=0, vld=0, wptr=0, ovf=0, full=0 immediately, without waiting for a clock edge. Outputs stay at these values while rst_n is low. The first write is accepted on the first rising edge after rst_n rises.
- All state is registered. Write-to-output latency is 1 clock: q and vld update on the edge that samples wr_en.
- Target index: tgt = auto_mode ? wptr : sel.
- Write (wr_en=1, clr=0):
  - q[tgt] <= din; vld[tgt] <= 1.
  - If auto_mode=1, wptr <= wptr+1 mod 8, so 7 wraps to 0.
  - If auto_mode=0, wptr holds its value. Switching modes never alters wptr.
- Overwrite: if a write hits a channel with vld[tgt]=1 and ack[tgt]=0 in the same cycle, ovf <= 1. The data is still overwritten. ovf stays set until clr or reset.
- Ack: for each i with ack[i]=1, vld[i] <= 0 on the next edge. q[i] is retained.
- Priority on vld:
  - Write and ack to the same channel in the same cycle: the write wins. vld stays 1, q takes din, no ovf.
  - Ack and write to different channels in the same cycle: both take effect independently.
  - ack on a channel with vld=0 has no effect and is not an error.
- clr=1: on the next edge q_bus=0, vld=0, wptr=0, ovf=0. clr has priority over wr_en and ack; a write in the same cycle is dropped and wptr does not advance.
- full = &vld, decoded from registers with no combinational path from inputs. A write while full in auto mode overwrites channel wptr and sets ovf.
- Outputs depend only on registered state. din, sel, wr_en and ack have no combinational path to any output.
- X on sel or din while wr_en=0 must not affect state.

Test Plan:
- Reset mid-run: after writing din=6'h2A to ch3, assert rst_n=0 between edges -> q_bus, vld, wptr, ovf all 0 before the next edge; first post-reset write lands on ch0 in auto mode.
- Auto fill and wrap: auto_mode=1, write din=1..8 on 8 consecutive cycles -> q0..q7 = 1..7,8; vld=8'hFF; full=1; wptr=0. A 9th write of 6'h3F -> q0=6'h3F, ovf=1, wptr=1.
- Manual select: auto_mode=0, write sel=5 din=6'h15 then sel=2 din=6'h0C -> q5=6'h15, q2=6'h0C, vld=8'b0010_0100, wptr unchanged at 0, full=0.
- Ack and simultaneous events:
  - ack=8'h20 alone -> vld[5]=0, q5 still 6'h15.
  - Same cycle: write sel=2 din=6'h07 with ack[2]=1 -> q2=6'h07, vld[2]=1, ovf stays 0.
- clr priority: with vld=8'hFF, ovf=1, wptr=3, assert clr=1 and wr_en=1 together -> next edge q_bus=0, vld=0, ovf=0, wptr=0; the write is dropped.
- Latency check: din changes 6'h11 -> 6'h22 with wr_en=1 on ch0 -> q0 shows 6'h11 one cycle after the first edge, never the pre-edge value combinationally.

Source files
------------

// File: rtl/demux_1a8_6b_reg.sv
// Registered 1-to-8 demultiplexer that steers one data stream into eight hold registers.
// Each channel has a valid flag with consumer ack; the block also keeps a full flag and a sticky overwrite error.
module demux_1a8_6b_reg #(
    parameter int WIDTH = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   din,
    input  logic [2:0]         sel,
    input  logic               wr_en,
    input  logic               auto_mode,
    input  logic               clr,
    input  logic [7:0]         ack,
    output logic [8*WIDTH-1:0] q_bus,
    output logic [7:0]         vld,
    output logic               full,
    output logic               ovf,
    output logic [2:0]         wptr
);

    logic [WIDTH-1:0] q [8];
    logic [2:0]       tgt;
    logic [7:0]       vld_nxt;
    logic             hit;

    assign tgt = auto_mode ? wptr : sel;
    assign hit = wr_en && vld[tgt] && !ack[tgt];

    // A write to a channel wins over an ack to that channel in the same cycle.
    always_comb begin
        vld_nxt = vld & ~ack;
        if (wr_en) begin
            vld_nxt[tgt] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                q[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < 8; i++) begin
                q[i] <= '0;
            end
        end else if (wr_en) begin
            q[tgt] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
        end else if (clr) begin
            vld <= '0;
        end else begin
            vld <= vld_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            ovf  <= 1'b0;
        end else if (clr) begin
            wptr <= '0;
            ovf  <= 1'b0;
        end else begin
            if (wr_en && auto_mode) begin
                wptr <= wptr + 3'd1;
            end
            if (hit) begin
                ovf <= 1'b1;
            end
        end
    end

    assign full = &vld;

    always_comb begin
        q_bus = '0;
        for (int i = 0; i < 8; i++) begin
            q_bus[WIDTH*i +: WIDTH] = q[i];
        end
    end

endmodule

// File: tb/tb_demux_1a8_6b_reg.sv
// Bench for demux_1a8_6b_reg: directed stimulus feeds a queue of expected states.
// A monitor pops each expected state and compares it with the outputs after every clock edge or reset event.
module tb_demux_1a8_6b_reg;

    logic        clk;
    logic        rst_n;
    logic [5:0]  din;
    logic [2:0]  sel;
    logic        wr_en;
    logic        auto_mode;
    logic        clr;
    logic [7:0]  ack;
    logic [47:0] q_bus;
    logic [7:0]  vld;
    logic        full;
    logic        ovf;
    logic [2:0]  wptr;

    demux_1a8_6b_reg #(.WIDTH(6)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .sel(sel),
        .wr_en(wr_en), .auto_mode(auto_mode), .clr(clr), .ack(ack),
        .q_bus(q_bus), .vld(vld), .full(full), .ovf(ovf), .wptr(wptr)
    );

    typedef struct {
        string       nm;
        logic [47:0] bus;
        logic [7:0]  v;
        logic        f;
        logic        o;
        logic [2:0]  p;
    } exp_t;

    exp_t sb[$];
    event chk_ev;
    int   checks = 0;
    int   errors = 0;

    logic [5:0] mq [8];
    logic [7:0] mv;
    logic [2:0] mp;
    logic       mo;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string nm);
        exp_t e;
        e.nm = nm;
        e.bus = '0;
        for (int i = 0; i < 8; i++) e.bus[6*i +: 6] = mq[i];
        e.v = mv;
        e.f = &mv;
        e.o = mo;
        e.p = mp;
        sb.push_back(e);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mq[i] = '0;
        mv = '0;
        mp = '0;
        mo = 1'b0;
    endtask

    task automatic cmp(input string nm, input string fld,
                       input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s got %h want %h", nm, fld, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk or chk_ev);
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                cmp(e.nm, "q_bus", q_bus, e.bus);
                cmp(e.nm, "vld", {40'd0, vld}, {40'd0, e.v});
                cmp(e.nm, "full", {47'd0, full}, {47'd0, e.f});
                cmp(e.nm, "ovf", {47'd0, ovf}, {47'd0, e.o});
                cmp(e.nm, "wptr", {45'd0, wptr}, {45'd0, e.p});
            end
        end
    end

    task automatic step(input logic w, input logic a, input logic [2:0] s,
                        input logic [5:0] d, input logic [7:0] k,
                        input logic c, input string nm);
        logic [2:0] t;
        logic [7:0] nv;
        @(negedge clk);
        wr_en = w; auto_mode = a; sel = s; din = d; ack = k; clr = c;
        if (c) begin
            model_reset();
        end else begin
            nv = mv & ~k;
            if (w) begin
                t = a ? mp : s;
                if (mv[t] && !k[t]) mo = 1'b1;
                mq[t] = d;
                nv[t] = 1'b1;
                if (a) mp = mp + 3'd1;
            end
            mv = nv;
        end
        push(nm);
    endtask

    task automatic idle_inputs();
        wr_en = 0; auto_mode = 0; sel = 0; din = 0; ack = 0; clr = 0;
    endtask

    task automatic mid_reset(input string nm);
        @(negedge clk);
        idle_inputs();
        #2 rst_n = 1'b0;
        model_reset();
        push(nm);
        -> chk_ev;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #2;
        push("por");
        -> chk_ev;
        @(negedge clk);
        rst_n = 1'b1;

        step(1, 0, 3'd3, 6'h2A, 8'h00, 0, "wr_ch3");
        mid_reset("mid_rst");
        step(1, 1, 3'd0, 6'h01, 8'h00, 0, "post_rst_ch0");
        for (int i = 2; i <= 8; i++) begin
            step(1, 1, 3'd0, 6'(i), 8'h00, 0, "auto_fill");
        end
        step(1, 1, 3'd0, 6'h3F, 8'h00, 0, "wrap_ovf");
        step(0, 0, 3'd0, 6'h00, 8'h00, 1, "clr1");
        step(1, 0, 3'd5, 6'h15, 8'h00, 0, "man_ch5");
        step(1, 0, 3'd2, 6'h0C, 8'h00, 0, "man_ch2");
        step(0, 0, 3'd0, 6'h00, 8'h20, 0, "ack_ch5");
        step(1, 0, 3'd2, 6'h07, 8'h04, 0, "wr_ack_same");
        step(0, 0, 3'd0, 6'h00, 8'h01, 0, "ack_empty");
        step(1, 0, 3'd6, 6'h2B, 8'h04, 0, "wr_ack_diff");
        step(0, 1, 3'bxxx, 6'bxxxxxx, 8'h00, 0, "x_idle");
        step(1, 1, 3'd0, 6'h33, 8'h00, 0, "auto_after_man");
        step(0, 0, 3'd0, 6'h00, 8'h00, 1, "clr2");
        for (int i = 0; i < 11; i++) begin
            step(1, 1, 3'd0, 6'(i + 9), 8'h00, 0, "fill_over");
        end
        step(1, 1, 3'd0, 6'h3E, 8'h00, 1, "clr_vs_wr");
        step(1, 0, 3'd0, 6'h11, 8'h00, 0, "lat_11");
        step(1, 0, 3'd0, 6'h22, 8'h00, 0, "lat_22");
        step(0, 0, 3'd0, 6'h00, 8'h00, 0, "idle_end");

        for (int n = 0; n < 20 && sb.size() > 0; n++) @(posedge clk);
        #3;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
